cache_controller: RTL

- Miss-handling sequencer for the read-only, N-way set-associative cache datapath.
- Latches each CPU read request and drives the lookup address into the datapath. On a hit it returns the selected word; on a miss it fetches the whole block from memory, writes it into a victim way, and returns the requested word.
- Sits between the CPU load port, the cache storage array and the next-level memory.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_victim_sel.sv | 60 ++++++
 rtl/cache_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the cache controller and its datapath.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPARE  = 2'd1,
        FETCH    = 2'd2,
        ALLOCATE = 2'd3
    } state_e;

    function automatic int calc_way_w(input int assoc);
        return (assoc > 1) ? assoc : 1;
    endfunction

    function automatic int calc_blk_w(input int line_w, input int off_w);
        return line_w * (1 << off_w);
    endfunction

    // Byte address layout: {tag, index, offset, 2'b00}
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w, input int off_w);
        return addr >> (idx_w + off_w + 2);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w, input int off_w);
        return (addr >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int off_w);
        return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise a per-set round-robin pointer.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int ASSOC   = 0,
    parameter int INDEX_W = 4,
    parameter int WAY_W   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2**ASSOC-1:0]   valid_vec,
    input  logic [INDEX_W-1:0]    index,
    input  logic                  advance,
    output logic [WAY_W-1:0]      victim_way,
    output logic                  victim_use_rr
);

    if (ASSOC == 0) begin : g_direct
        logic unused_ok;
        assign unused_ok     = ^{clk, reset, valid_vec, index, advance};
        assign victim_way    = '0;
        assign victim_use_rr = 1'b0;
    end else begin : g_assoc
        localparam int WAYS  = 2**ASSOC;
        localparam int NSETS = 2**INDEX_W;

        logic [WAY_W-1:0] rr_q [NSETS];
        logic [WAY_W-1:0] rr_d [NSETS];

        always_comb begin
            rr_d = rr_q;
            if (advance) begin
                rr_d[index] = rr_q[index] + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < NSETS; i++) begin
                    rr_q[i] <= '0;
                end
            end else begin
                rr_q <= rr_d;
            end
        end

        // Scan downward so the lowest-numbered invalid way wins.
        always_comb begin
            victim_way    = rr_q[index];
            victim_use_rr = 1'b1;
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (!valid_vec[i]) begin
                    victim_way    = WAY_W'(i);
                    victim_use_rr = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Miss-handling sequencer for a read-only set-associative cache.
// Optional hit/miss counters are built when CACHE_CTRL_PERF_COUNTERS_EN is defined.
module cache_controller
    import cache_pkg::*;
#(
    parameter int line_size   = 32,
    parameter int assiotivity = 0,
    parameter int index_depth = 4,
    parameter int offset_size = 2,
    localparam int tag_size   = line_size - index_depth - offset_size - 2,
    localparam int WAY_W      = calc_way_w(assiotivity),
    localparam int BLK_W      = calc_blk_w(line_size, offset_size),
    localparam int OFF_W      = (offset_size > 0) ? offset_size : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cpu_read,
    input  logic [line_size-1:0]              cpu_address,
    output logic                              cpu_busywait,
    output logic [line_size-1:0]              cpu_readdata,
    output logic [line_size-1:0]              lookup_address,
    input  logic                              cache_hit,
    input  logic [line_size-1:0]              cache_data,
    input  logic [2**assiotivity-1:0]         cache_valid_vec,
    output logic                              cache_write_en,
    output logic [WAY_W-1:0]                  cache_write_way,
    output logic [index_depth-1:0]            cache_write_index,
    output logic [tag_size-1:0]               cache_write_tag,
    output logic [BLK_W-1:0]                  cache_write_block,
    output logic                              mem_read,
    output logic [line_size-offset_size-3:0]  mem_address,
    input  logic                              mem_busywait,
    input  logic [BLK_W-1:0]                  mem_readdata
`ifdef CACHE_CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count
`endif
);

    state_e                 state_q, state_d;
    logic [line_size-1:0]   addr_q, addr_d;
    logic [line_size-1:0]   rdata_q, rdata_d;
    logic [BLK_W-1:0]       blk_q, blk_d;
    logic [WAY_W-1:0]       victim_q, victim_d;
    logic                   rr_used_q, rr_used_d;
    logic [WAY_W-1:0]       victim_way;
    logic                   victim_use_rr;
    logic [index_depth-1:0] lookup_index;
    logic [OFF_W-1:0]       word_sel;

    assign lookup_index = index_depth'(addr_index(64'(addr_q), index_depth, offset_size));
    assign word_sel     = OFF_W'(addr_offset(64'(addr_q), offset_size));

    cache_victim_sel #(
        .ASSOC   (assiotivity),
        .INDEX_W (index_depth),
        .WAY_W   (WAY_W)
    ) u_victim_sel (
        .clk           (clk),
        .reset         (reset),
        .valid_vec     (cache_valid_vec),
        .index         (lookup_index),
        .advance       ((state_q == ALLOCATE) && rr_used_q),
        .victim_way    (victim_way),
        .victim_use_rr (victim_use_rr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (cpu_read) state_d = COMPARE;
            COMPARE:  state_d = cache_hit ? IDLE : FETCH;
            FETCH:    if (!mem_busywait) state_d = ALLOCATE;
            ALLOCATE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_busywait   = 1'b1;
        mem_read       = 1'b0;
        cache_write_en = 1'b0;
        unique case (state_q)
            IDLE:     cpu_busywait   = cpu_read;
            FETCH:    mem_read       = 1'b1;
            ALLOCATE: cache_write_en = 1'b1;
            default:  ;
        endcase
    end

    // The victim is frozen at COMPARE so the pointer advances only if it chose the way.
    always_comb begin
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        blk_d     = blk_q;
        victim_d  = victim_q;
        rr_used_d = rr_used_q;
        unique case (state_q)
            IDLE:     if (cpu_read) addr_d = cpu_address;
            COMPARE: begin
                if (cache_hit) begin
                    rdata_d = cache_data;
                end else begin
                    victim_d  = victim_way;
                    rr_used_d = victim_use_rr;
                end
            end
            FETCH:    if (!mem_busywait) blk_d = mem_readdata;
            ALLOCATE: rdata_d = blk_q[word_sel*line_size +: line_size];
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            rdata_q   <= '0;
            blk_q     <= '0;
            victim_q  <= '0;
            rr_used_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            blk_q     <= blk_d;
            victim_q  <= victim_d;
            rr_used_q <= rr_used_d;
        end
    end

    assign cpu_readdata      = rdata_q;
    assign lookup_address    = addr_q;
    assign mem_address       = addr_q[line_size-1:offset_size+2];
    assign cache_write_way   = victim_q;
    assign cache_write_index = lookup_index;
    assign cache_write_tag   = tag_size'(addr_tag(64'(addr_q), index_depth, offset_size));
    assign cache_write_block = blk_q;

`ifdef CACHE_CTRL_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == COMPARE) begin
            if (cache_hit) hit_count_d  = hit_count_q + 32'd1;
            else           miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
